tt_sweep_checker: RTL and testbench

- Self-contained sweep-and-check stage wrapped around a 4-input combinational Boolean-equation block.
- Upstream role: drives the equation block's inputs a, b, c, d through all 16 combinations in ascending order, holding each for a fixed dwell.
- Downstream role: samples the block's output z for each combination, assembles a 16-bit truth table and compares it with an expected word.
- Used for on-chip / FPGA self-check of equation blocks; replaces hand-written exhaustive stimulus.

---
 rtl/tt_sweep_checker.sv | 215 +++++++++++++++++++++
 tb/tb_tt_sweep_checker.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker
// Exhaustive truth-table checker for a 4-input combinational equation block.
// Walks {a,b,c,d} through 0000..1111, holding each code for DWELL cycles.
// Samples z on the last cycle of each dwell and builds a 16-bit truth table.
// Compares the table with the golden word that was latched at start.
//
// Parameters:
//   DWELL        cycles each combination is held (1..65535)
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        sweep request, accepted only when idle
//   expected     golden truth table, bit i = z for {a,b,c,d} == i
//   z            equation block output
//   a,b,c,d      equation block inputs, a is the index MSB
//   busy         sweep in progress
//   done         one-cycle pulse at the end of a sweep
//   pass         truth_table == expected, held until the next accepted start
//   truth_table  captured z values, bit i = z for combination i
//
// Optional build macro TT_FAIL_IDX_EN adds:
//   fail_valid   registered with pass, equals !pass
//   fail_idx     lowest mismatching combination, 0 on pass
//
// state  | meaning
// -------+---------------------------------------------------------
// S_IDLE | outputs parked at 0000, waiting for start
// S_RUN  | driving idx onto a..d, capturing z at the end of each dwell
// S_DONE | single-cycle done pulse, compare result already registered

module tt_sweep_checker #(
    parameter int DWELL = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        z,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] truth_table
`ifdef TT_FAIL_IDX_EN
    ,
    output logic        fail_valid,
    output logic [3:0]  fail_idx
`endif
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_exp;
    logic [15:0]      r_tt;
    logic [3:0]       r_abcd;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    state_t           w_state_nxt;
    logic [3:0]       w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [15:0]      w_exp_nxt;
    logic [15:0]      w_tt_nxt;
    logic [3:0]       w_abcd_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic             w_pass_nxt;
    logic [15:0]      w_tt_cap;

`ifdef TT_FAIL_IDX_EN
    logic             r_fail_valid;
    logic [3:0]       r_fail_idx;
    logic             w_fail_valid_nxt;
    logic [3:0]       w_fail_idx_nxt;

    function automatic logic [3:0] f_lowest_set(input logic [15:0] v);
        f_lowest_set = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) f_lowest_set = 4'(i);
        end
    endfunction
`endif

    // Table including the bit being captured this cycle; the final compare
    // must see bit 15 on the same edge that it is written.
    always_comb begin
        w_tt_cap        = r_tt;
        w_tt_cap[r_idx] = z;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_exp_nxt   = r_exp;
        w_tt_nxt    = r_tt;
        w_abcd_nxt  = r_abcd;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_pass_nxt  = r_pass;
`ifdef TT_FAIL_IDX_EN
        w_fail_valid_nxt = r_fail_valid;
        w_fail_idx_nxt   = r_fail_idx;
`endif
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                w_abcd_nxt = 4'd0;
                if (start) begin
                    w_state_nxt = S_RUN;
                    w_exp_nxt   = expected;
                    w_tt_nxt    = 16'd0;
                    w_pass_nxt  = 1'b0;
                    w_idx_nxt   = 4'd0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_abcd_nxt  = 4'd0;
`ifdef TT_FAIL_IDX_EN
                    w_fail_valid_nxt = 1'b0;
                    w_fail_idx_nxt   = 4'd0;
`endif
                end
            end
            S_RUN: begin
                if (r_cnt == CNT_LAST) begin
                    w_tt_nxt  = w_tt_cap;
                    w_cnt_nxt = '0;
                    if (r_idx == 4'd15) begin
                        w_state_nxt = S_DONE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_abcd_nxt  = 4'd0;
                        w_pass_nxt  = (w_tt_cap == r_exp);
`ifdef TT_FAIL_IDX_EN
                        w_fail_valid_nxt = (w_tt_cap != r_exp);
                        w_fail_idx_nxt   = f_lowest_set(w_tt_cap ^ r_exp);
`endif
                    end else begin
                        w_idx_nxt  = r_idx + 4'd1;
                        w_abcd_nxt = r_idx + 4'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_exp   <= 16'd0;
            r_tt    <= 16'd0;
            r_abcd  <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_exp   <= w_exp_nxt;
            r_tt    <= w_tt_nxt;
            r_abcd  <= w_abcd_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

`ifdef TT_FAIL_IDX_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_valid <= 1'b0;
            r_fail_idx   <= 4'd0;
        end else begin
            r_fail_valid <= w_fail_valid_nxt;
            r_fail_idx   <= w_fail_idx_nxt;
        end
    end

    assign fail_valid = r_fail_valid;
    assign fail_idx   = r_fail_idx;
`endif

    assign {a, b, c, d}  = r_abcd;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign truth_table   = r_tt;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three instances (DWELL 20, 4, 1) share start,
// expected and reset. Each sees z = ztab[{a,b,c,d}], so ztab is the truth
// table of the equation block. A timeline model derives every output from
// the accept cycle of the current sweep; ztab only changes while all idle.

module tb_tt_sweep_checker;

    localparam int N   = 3;
    localparam int DW0 = 20;
    localparam int DW1 = 4;
    localparam int DW2 = 1;

    function automatic int dw(input int n);
        case (n)
            0:       return DW0;
            1:       return DW1;
            default: return DW2;
        endcase
    endfunction

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected = 16'd0;
    logic [15:0] ztab = 16'd0;

    logic [N-1:0][3:0]  w_abcd;
    logic [N-1:0]       w_busy;
    logic [N-1:0]       w_done;
    logic [N-1:0]       w_pass;
    logic [N-1:0]       w_z;
    logic [N-1:0][15:0] w_tt;
`ifdef TT_FAIL_IDX_EN
    logic [N-1:0]       w_fv;
    logic [N-1:0][3:0]  w_fi;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_on   = 1'b0;
    int done_cnt [N];
    int done_q2 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign w_z[0] = ztab[w_abcd[0]];
    assign w_z[1] = ztab[w_abcd[1]];
    assign w_z[2] = ztab[w_abcd[2]];

    tt_sweep_checker #(.DWELL(DW0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .z(w_z[0]),
        .a(w_abcd[0][3]), .b(w_abcd[0][2]), .c(w_abcd[0][1]), .d(w_abcd[0][0]),
        .busy(w_busy[0]), .done(w_done[0]), .pass(w_pass[0]), .truth_table(w_tt[0])
`ifdef TT_FAIL_IDX_EN
        , .fail_valid(w_fv[0]), .fail_idx(w_fi[0])
`endif
    );

    tt_sweep_checker #(.DWELL(DW1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .z(w_z[1]),
        .a(w_abcd[1][3]), .b(w_abcd[1][2]), .c(w_abcd[1][1]), .d(w_abcd[1][0]),
        .busy(w_busy[1]), .done(w_done[1]), .pass(w_pass[1]), .truth_table(w_tt[1])
`ifdef TT_FAIL_IDX_EN
        , .fail_valid(w_fv[1]), .fail_idx(w_fi[1])
`endif
    );

    tt_sweep_checker #(.DWELL(DW2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .expected(expected), .z(w_z[2]),
        .a(w_abcd[2][3]), .b(w_abcd[2][2]), .c(w_abcd[2][1]), .d(w_abcd[2][0]),
        .busy(w_busy[2]), .done(w_done[2]), .pass(w_pass[2]), .truth_table(w_tt[2])
`ifdef TT_FAIL_IDX_EN
        , .fail_valid(w_fv[2]), .fail_idx(w_fi[2])
`endif
    );

    // Reference model: a sweep is "accept edge t0"; everything else follows
    // from the elapsed edge count el = edge - t0:
    //   el in [0,16D)  running, index el/D
    //   el == (k+1)*D  combination k captured
    //   el == 16D      done cycle, compare result valid
    //   el >  16D      idle again
    bit          m_act [N];
    int          m_t0  [N];
    logic [15:0] m_exp [N];
    logic [15:0] m_tt  [N];
    logic        m_pass[N];
    logic        m_fv  [N];
    logic [3:0]  m_fi  [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < N; n++) begin
                m_act[n]  <= 1'b0;
                m_t0[n]   <= 0;
                m_exp[n]  <= 16'd0;
                m_tt[n]   <= 16'd0;
                m_pass[n] <= 1'b0;
                m_fv[n]   <= 1'b0;
                m_fi[n]   <= 4'd0;
            end
        end else begin
            for (int n = 0; n < N; n++) begin
                int          dd;
                int          e;
                int          el;
                bit          idle_before;
                logic [15:0] tt_n;
                logic [15:0] diff;
                dd = dw(n);
                e  = cyc + 1;
                idle_before = !m_act[n] || ((e - 1 - m_t0[n]) >= 16 * dd + 1);
                if (!idle_before) begin
                    el   = e - m_t0[n];
                    tt_n = m_tt[n];
                    if (el >= dd && el <= 16 * dd && (el % dd) == 0)
                        tt_n[el / dd - 1] = ztab[el / dd - 1];
                    m_tt[n] <= tt_n;
                    if (el == 16 * dd) begin
                        diff      = tt_n ^ m_exp[n];
                        m_pass[n] <= (diff == 16'd0);
                        m_fv[n]   <= (diff != 16'd0);
                        m_fi[n]   <= 4'd0;
                        for (int k = 0; k < 16; k++) begin
                            if (diff[k]) begin
                                m_fi[n] <= 4'(k);
                                break;
                            end
                        end
                    end
                end else if (start) begin
                    m_act[n]  <= 1'b1;
                    m_t0[n]   <= e;
                    m_exp[n]  <= expected;
                    m_tt[n]   <= 16'd0;
                    m_pass[n] <= 1'b0;
                    m_fv[n]   <= 1'b0;
                    m_fi[n]   <= 4'd0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int n = 0; n < N; n++) begin
                int          dd;
                int          el;
                logic        run;
                logic        dn;
                logic [22:0] got;
                logic [22:0] want;
                dd   = dw(n);
                el   = cyc - m_t0[n];
                run  = m_act[n] && (el >= 0) && (el < 16 * dd);
                dn   = m_act[n] && (el == 16 * dd);
                want = {run, dn, m_pass[n], (run ? 4'(el / dd) : 4'd0), m_tt[n]};
                got  = {w_busy[n], w_done[n], w_pass[n], w_abcd[n], w_tt[n]};
                checks++;
                if (got !== want) begin
                    failures++;
                    $display("FAIL outputs dut%0d cyc=%0d {busy,done,pass,abcd,tt}: got %h want %h",
                             n, cyc, got, want);
                end
`ifdef TT_FAIL_IDX_EN
                checks++;
                if ({w_fv[n], w_fi[n]} !== {m_fv[n], m_fi[n]}) begin
                    failures++;
                    $display("FAIL fail_info dut%0d cyc=%0d {valid,idx}: got %h want %h",
                             n, cyc, {w_fv[n], w_fi[n]}, {m_fv[n], m_fi[n]});
                end
`endif
                if (w_done[n] === 1'b1) begin
                    done_cnt[n]++;
                    if (n == 2) done_q2.push_back(cyc);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, got, want);
        end
    endtask

    task automatic wait_cyc(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    // Negedge following edge number e; callers always enter before that edge.
    task automatic at_neg(input int e);
        do @(negedge clk); while (cyc < e);
    endtask

    task automatic pulse_start(output int e0);
        start = 1'b1;
        e0    = cyc + 1;
        wait_cyc(1);
        start = 1'b0;
    endtask

    initial begin
        int e0;
        int e1;
        int dc;
        int q0;
        int rst_at;

        for (int n = 0; n < N; n++) done_cnt[n] = 0;
        #1 rst_n = 1'b0;
        #1 chk_on = 1'b1;
        wait_cyc(3);
        check("reset_busy", {29'd0, w_busy}, 32'd0);
        check("reset_tt0", {16'd0, w_tt[0]}, 32'd0);
        rst_n = 1'b1;
        wait_cyc(2);

        // (a&b)|(c&d), matching golden word
        ztab = 16'hF888;
        expected = 16'hF888;
        pulse_start(e0);
        at_neg(e0 + 16);
        check("d2_done", {31'd0, w_done[2]}, 32'd1);
        check("d2_tt", {16'd0, w_tt[2]}, 32'hF888);
        at_neg(e0 + 64);
        check("d1_done_at_64", {31'd0, w_done[1]}, 32'd1);
        check("d1_pass", {31'd0, w_pass[1]}, 32'd1);
        at_neg(e0 + 103);
        check("d0_abcd_idx5", {28'd0, w_abcd[0]}, 32'd5);
        at_neg(e0 + 319);
        check("d0_not_done_319", {30'd0, w_busy[0], w_done[0]}, 32'd2);
        at_neg(e0 + 320);
        check("d0_done_320", {30'd0, w_busy[0], w_done[0]}, 32'd1);
        check("d0_pass", {31'd0, w_pass[0]}, 32'd1);
        check("d0_tt", {16'd0, w_tt[0]}, 32'hF888);
        check("model_tt", {16'd0, m_tt[0]}, 32'hF888);
        at_neg(e0 + 321);
        check("d0_pass_held", {30'd0, w_done[0], w_pass[0]}, 32'd1);
        wait_cyc(3);

        // golden word differs at combination 0
        expected = 16'hF889;
        pulse_start(e0);
        at_neg(e0 + 320);
        check("mis_pass", {31'd0, w_pass[0]}, 32'd0);
        check("mis_tt", {16'd0, w_tt[0]}, 32'hF888);
`ifdef TT_FAIL_IDX_EN
        check("mis_fail_valid", {31'd0, w_fv[0]}, 32'd1);
        check("mis_fail_idx", {28'd0, w_fi[0]}, 32'd0);
`endif
        wait_cyc(3);

        // parity, with a restart attempt while dut0 is at idx 5
        ztab = 16'h6996;
        expected = 16'h6996;
        pulse_start(e0);
        dc = done_cnt[0];
        at_neg(e0 + 37);
        check("d1_abcd_idx9", {28'd0, w_abcd[1]}, 32'd9);
        at_neg(e0 + 64);
        check("par_d1_done", {30'd0, w_done[1], w_pass[1]}, 32'd3);
        check("par_d1_tt", {16'd0, w_tt[1]}, 32'h6996);
        at_neg(e0 + 103);
        pulse_start(e1);
        at_neg(e0 + 320);
        check("restart_ignored_done", {30'd0, w_done[0], w_pass[0]}, 32'd3);
        at_neg(e0 + 322);
        check("single_done", done_cnt[0] - dc, 32'd1);
        wait_cyc(3);

        // reset in the middle of idx 7
        ztab = 16'hF888;
        expected = 16'hF888;
        pulse_start(e0);
        at_neg(e0 + 149);
        wait_cyc(1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {w_busy[0], w_done[0], w_pass[0], w_abcd[0], w_tt[0]}, 32'd0);
        dc = done_cnt[0];
        wait_cyc(2);
        rst_n = 1'b1;
        wait_cyc(340);
        check("abort_no_done", done_cnt[0] - dc, 32'd0);
        pulse_start(e0);
        at_neg(e0 + 320);
        check("after_abort_pass", {30'd0, w_done[0], w_pass[0]}, 32'd3);
        wait_cyc(3);

        // start held high, z tied low
        ztab = 16'h0000;
        expected = 16'h0000;
        q0 = done_q2.size();
        start = 1'b1;
        e0 = cyc + 1;
        wait_cyc(56);
        start = 1'b0;
        check("b2b_count", {31'd0, done_q2.size() - q0 >= 3}, 32'd1);
        if (done_q2.size() - q0 >= 3) begin
            check("b2b_first", done_q2[q0] - e0, 32'd16);
            check("b2b_gap1", done_q2[q0+1] - done_q2[q0], 32'd18);
            check("b2b_gap2", done_q2[q0+2] - done_q2[q0+1], 32'd18);
        end
        wait_cyc(340);

        // randomized tables, golden words, start noise and occasional resets
        for (int it = 0; it < 12; it++) begin
            ztab = 16'($urandom);
            if ($urandom_range(0, 1) == 1) expected = ztab;
            else expected = ztab ^ (16'd1 << $urandom_range(0, 15));
            rst_at = (it % 4 == 3) ? int'($urandom_range(10, 300)) : -1;
            pulse_start(e0);
            for (int k = 0; k < 330; k++) begin
                start    = ($urandom_range(0, 7) == 0);
                expected = 16'($urandom);
                rst_n    = (k != rst_at);
                wait_cyc(1);
            end
            start = 1'b0;
            rst_n = 1'b1;
            wait_cyc(340);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
